uart_rx_fifo: RTL and testbench

//  Parametrised RS232C receiver for the simulation UART model: oversampled deserializer with

---
 rtl/uart_rx_fifo.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Oversampling RS232C receiver with glitch-filtered start detection, parity/framing
// checks and a show-ahead receive FIFO exposed through a valid/ready handshake.
module uart_rx_fifo #(
  parameter int unsigned CLK_PER_BIT = 5,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 VALID,
  input  logic                 READY,
  output logic                 PARITY_ERR,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
  output logic                 BUSY
);

  localparam int unsigned TW = $clog2(CLK_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLK_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_END = TW'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rxs_q;
  logic [TW-1:0]        timer_q, timer_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic                 stopcnt_q, stopcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 push_req, perr_pulse_d, ferr_pulse_d;
  logic                 perr_pulse_q, ferr_pulse_q, overrun_q;
  logic                 par;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 full, pop, push;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + TW'(1);
    bitcnt_d     = bitcnt_q;
    stopcnt_d    = stopcnt_q;
    shreg_d      = shreg_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    push_req     = 1'b0;
    perr_pulse_d = 1'b0;
    ferr_pulse_d = 1'b0;
    par          = ^{shreg_q, rxs_q};
    unique case (state_q)
      S_IDLE: begin
        timer_d   = '0;
        bitcnt_d  = '0;
        stopcnt_d = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        if (!rxs_q) state_d = S_START;
      end
      S_START: begin
        if (timer_q == HALF_M1) begin
          timer_d = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (timer_q == BIT_END) begin
          timer_d  = '0;
          shreg_d  = {rxs_q, shreg_q[DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + BW'(1);
          if (bitcnt_q == BW'(DATA_BITS - 1))
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          perr_d  = (PARITY == 1) ? ~par : par;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (timer_q == BIT_END) begin
          timer_d   = '0;
          ferr_d    = ferr_q | ~rxs_q;
          stopcnt_d = stopcnt_q + 1'b1;
          if (stopcnt_q == 1'(STOP_BITS - 1)) begin
            // framing beats parity: exactly one outcome per character
            if (ferr_d) begin
              ferr_pulse_d = 1'b1;
              state_d      = S_BREAK;
            end else if (perr_q) begin
              perr_pulse_d = 1'b1;
              state_d      = S_IDLE;
            end else begin
              push_req = 1'b1;
              state_d  = S_IDLE;
            end
          end
        end
      end
      S_BREAK: begin
        timer_d = '0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = (count_q != '0) && READY;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push  = push_req && (!full || pop);

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      timer_q      <= '0;
      bitcnt_q     <= '0;
      stopcnt_q    <= 1'b0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      perr_pulse_q <= 1'b0;
      ferr_pulse_q <= 1'b0;
      overrun_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= RXD;
      rxs_q        <= rx_meta_q;
      timer_q      <= timer_d;
      bitcnt_q     <= bitcnt_d;
      stopcnt_q    <= stopcnt_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      perr_pulse_q <= perr_pulse_d;
      ferr_pulse_q <= ferr_pulse_d;
      overrun_q    <= push_req && full && !pop;
      if (push) begin
        mem_q[wr_ptr_q] <= shreg_q;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign DATA       = mem_q[rd_ptr_q];
  assign VALID      = (count_q != '0);
  assign PARITY_ERR = perr_pulse_q;
  assign FRAME_ERR  = ferr_pulse_q;
  assign OVERRUN    = overrun_q;
  assign BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a default instance and an even-parity/2-stop instance, each
// scored against a queue model of which characters should emerge and which flags pulse.
module tb_uart_rx_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd     [2];
  logic       ready   [2];
  logic [7:0] data_o  [2];
  logic       valid_o [2];
  logic       perr_o  [2];
  logic       ferr_o  [2];
  logic       ovr_o   [2];
  logic       busy_o  [2];

  int checks = 0;
  int failures = 0;
  int exp_perr [2] = '{0, 0};
  int exp_ferr [2] = '{0, 0};
  int exp_ovr  [2] = '{0, 0};
  int seen_perr[2] = '{0, 0};
  int seen_ferr[2] = '{0, 0};
  int seen_ovr [2] = '{0, 0};
  int spurious [2] = '{0, 0};
  int valid_cyc[2] = '{0, 0};
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  always #5 clk = ~clk;

  uart_rx_fifo dut0 (
    .CLK(clk), .RST_X(rst_n), .RXD(rxd[0]), .DATA(data_o[0]), .VALID(valid_o[0]),
    .READY(ready[0]), .PARITY_ERR(perr_o[0]), .FRAME_ERR(ferr_o[0]), .OVERRUN(ovr_o[0]),
    .BUSY(busy_o[0])
  );

  uart_rx_fifo #(.CLK_PER_BIT(6), .PARITY(2), .STOP_BITS(2)) dut1 (
    .CLK(clk), .RST_X(rst_n), .RXD(rxd[1]), .DATA(data_o[1]), .VALID(valid_o[1]),
    .READY(ready[1]), .PARITY_ERR(perr_o[1]), .FRAME_ERR(ferr_o[1]), .OVERRUN(ovr_o[1]),
    .BUSY(busy_o[1])
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] qpop(input int u);
    return (u == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  task automatic qpush(input int u, input logic [7:0] d);
    if (u == 0) q0.push_back(d); else q1.push_back(d);
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst_n) begin
        if (perr_o[u])  seen_perr[u]++;
        if (ferr_o[u])  seen_ferr[u]++;
        if (ovr_o[u])   seen_ovr[u]++;
        if (valid_o[u]) valid_cyc[u]++;
        if (valid_o[u] && ready[u]) begin
          if (qsize(u) == 0) spurious[u]++;
          else check((u == 0) ? "rx_data0" : "rx_data1", data_o[u], qpop(u));
        end
      end
    end
  end

  task automatic drive(input int u, input logic b, input int n);
    if (u == 0) rxd[0] = b; else rxd[1] = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // stops[i] is the level sent for stop bit i; a low last stop is held for 'hold'
  // cycles and then released high for one bit time when rel is set
  task automatic send(input int u, input logic [7:0] d, input bit flip,
                      input logic [1:0] stops, input int hold, input bit rel);
    int c;
    logic last, bad;
    c    = (u == 0) ? 5 : 6;
    last = (u == 0) ? stops[0] : stops[1];
    bad  = (u == 0) ? !stops[0] : !(stops[0] && stops[1]);
    if (bad) exp_ferr[u]++;
    else if (u == 1 && flip) exp_perr[u]++;
    else if (!ready[u] && qsize(u) >= DEPTH) exp_ovr[u]++;
    else qpush(u, d);
    drive(u, 1'b0, c);
    for (int i = 0; i < 8; i++) drive(u, d[i], c);
    if (u == 1) drive(u, (^d) ^ flip, c);
    drive(u, stops[0], c);
    if (u == 1) drive(u, stops[1], c);
    if (!last) begin
      drive(u, 1'b0, hold);
      if (rel) drive(u, 1'b1, c);
    end
  endtask

  task automatic checkpoint(input int u, input string tag);
    check({tag, "_pending"}, qsize(u), 0);
    check({tag, "_perr"}, seen_perr[u], exp_perr[u]);
    check({tag, "_ferr"}, seen_ferr[u], exp_ferr[u]);
    check({tag, "_ovr"}, seen_ovr[u], exp_ovr[u]);
    check({tag, "_spurious"}, spurious[u], 0);
  endtask

  task automatic random_frames(input int u, input int n);
    logic [7:0] d;
    int kind;
    logic [1:0] st;
    for (int k = 0; k < n; k++) begin
      d    = 8'($urandom);
      kind = $urandom_range(0, 9);
      st   = 2'b11;
      if (kind == 0) st = (u == 0) ? 2'b10 : 2'($urandom_range(0, 2));
      send(u, d, (u == 1) && (kind == 1), st, $urandom_range(0, 15), 1'b1);
      drive(u, 1'b1, $urandom_range(0, 2) * ((u == 0) ? 5 : 6));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v0;
    rst_n = 1'b0;
    rxd[0] = 1'b1; rxd[1] = 1'b1;
    ready[0] = 1'b1; ready[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_data", data_o[0], 0);
    check("rst_valid", valid_o[0], 0);
    check("rst_busy", busy_o[0], 0);
    check("rst_flags", {perr_o[0], ferr_o[0], ovr_o[0]}, 0);
    @(posedge clk); #1;

    // single clean character, popped immediately
    v0 = valid_cyc[0];
    send(0, 8'hA5, 1'b0, 2'b11, 0, 1'b1);
    drive(0, 1'b1, 15);
    check("a5_valid_cycles", valid_cyc[0] - v0, 1);
    checkpoint(0, "a5");

    // one-cycle low glitch must not start a frame
    drive(0, 1'b0, 1);
    drive(0, 1'b1, 10);
    @(negedge clk);
    check("glitch_busy", busy_o[0], 0);
    checkpoint(0, "glitch");
    @(posedge clk); #1;

    // even parity: bad parity dropped, then good parity accepted
    send(1, 8'h03, 1'b1, 2'b11, 0, 1'b1);
    drive(1, 1'b1, 12);
    checkpoint(1, "par_bad");
    send(1, 8'h03, 1'b0, 2'b11, 0, 1'b1);
    drive(1, 1'b1, 12);
    checkpoint(1, "par_good");

    // framing error with a held-low line
    send(0, 8'h55, 1'b0, 2'b10, 20, 1'b0);
    @(negedge clk);
    check("break_busy_low", busy_o[0], 1);
    @(posedge clk); #1;
    drive(0, 1'b1, 2);
    @(negedge clk);
    check("break_busy_sync", busy_o[0], 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("break_busy_idle", busy_o[0], 0);
    @(posedge clk); #1;
    drive(0, 1'b1, 5);
    checkpoint(0, "frame");

    // overrun with the consumer stalled, then in-order drain
    ready[0] = 1'b0;
    for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b0, 2'b11, 0, 1'b1);
    drive(0, 1'b1, 10);
    check("ovr_count", seen_ovr[0], exp_ovr[0]);
    check("ovr_valid", valid_o[0], 1);
    check("ovr_head", data_o[0], 8'h01);
    ready[0] = 1'b1;
    drive(0, 1'b1, 10);
    checkpoint(0, "drain");

    // reset mid-frame clears the FIFO and the partial character
    ready[0] = 1'b0;
    send(0, 8'hAA, 1'b0, 2'b11, 0, 1'b1);
    drive(0, 1'b1, 3);
    check("pre_rst_data", data_o[0], 8'hAA);
    drive(0, 1'b0, 5);
    for (int i = 0; i < 3; i++) drive(0, 1'b1, 5);
    drive(0, 1'b1, 2);
    check("pre_rst_busy", busy_o[0], 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q0.delete();
    @(negedge clk);
    check("mid_rst_valid", valid_o[0], 0);
    check("mid_rst_busy", busy_o[0], 0);
    check("mid_rst_data", data_o[0], 0);
    check("mid_rst_flags", {perr_o[0], ferr_o[0], ovr_o[0]}, 0);
    @(posedge clk); #1;
    ready[0] = 1'b1;
    drive(0, 1'b1, 60);
    send(0, 8'h3C, 1'b0, 2'b11, 0, 1'b1);
    drive(0, 1'b1, 12);
    checkpoint(0, "post_rst");

    random_frames(0, 30);
    drive(0, 1'b1, 20);
    checkpoint(0, "rand0");
    random_frames(1, 30);
    drive(1, 1'b1, 20);
    checkpoint(1, "rand1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
